// File: rtl/motor_pkg.sv
// motor_pkg -- shared state and direction types for the door motor controller.
`default_nettype none

package motor_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MOVE_UP = 3'd1,
    MOVE_DN = 3'd2,
    DEAD    = 3'd3,
    FAULT   = 3'd4
  } state_t;

  typedef enum logic {
    UP = 1'b0,
    DN = 1'b1
  } dir_t;

endpackage

`default_nettype wire

// File: rtl/motor_run_timer.sv
// motor_run_timer -- saturating per-state cycle counter with run-timeout and dead-time compares.
`default_nettype none

module motor_run_timer #(
  parameter int RUN_TIMEOUT = 1024,
  parameter int DEAD_CYCLES = 4,
  parameter int CNT_W       = $clog2(RUN_TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic run_expired,
  output logic dead_done
);

  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over count so a new state always starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign run_expired = (cnt_q == RUN_LAST);
  assign dead_done   = (cnt_q == DEAD_LAST);

endmodule

`default_nettype wire

// File: rtl/door_motor_ctrl.sv
// door_motor_ctrl -- single-button reversible door drive with obstruction reverse,
// dead time, run watchdog and latched fault.
`default_nettype none

module door_motor_ctrl
  import motor_pkg::*;
#(
  parameter int RUN_TIMEOUT = 1024,
  parameter int DEAD_CYCLES = 4,
  parameter int CNT_W       = $clog2(RUN_TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       activate,
  input  logic       up_limit,
  input  logic       dn_limit,
  input  logic       obstruct,
  input  logic       clear_fault,
  output logic       motor_up,
  output logic       motor_dn,
  output logic       fault,
  output logic [2:0] state_o
);

  state_t state_q, state_d;
  dir_t   last_dir_q, last_dir_d;
  logic   activate_q;
  logic   motor_up_q, motor_up_d;
  logic   motor_dn_q, motor_dn_d;
  logic   fault_q, fault_d;
  logic   act_edge;
  logic   both_limits;
  logic   timer_clr, timer_en;
  logic   run_expired, dead_done;

  assign act_edge    = activate & ~activate_q;
  assign both_limits = up_limit & dn_limit;
  assign timer_clr   = (state_d != state_q);
  assign timer_en    = (state_q == MOVE_UP) || (state_q == MOVE_DN) || (state_q == DEAD);

  motor_run_timer #(
    .RUN_TIMEOUT (RUN_TIMEOUT),
    .DEAD_CYCLES (DEAD_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (timer_clr),
    .en          (timer_en),
    .run_expired (run_expired),
    .dead_done   (dead_done)
  );

  // Edge register resets high so a button held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_dir_q <= UP;
      activate_q <= 1'b1;
      motor_up_q <= 1'b0;
      motor_dn_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
      activate_q <= activate;
      motor_up_q <= motor_up_d;
      motor_dn_q <= motor_dn_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    case (state_q)
      IDLE: begin
        if (both_limits)   state_d = FAULT;
        else if (act_edge) begin
          if (up_limit)             state_d = MOVE_DN;
          else if (dn_limit)        state_d = MOVE_UP;
          else if (last_dir_q == UP) state_d = MOVE_DN;
          else                      state_d = MOVE_UP;
        end
      end
      MOVE_DN: begin
        if (both_limits)      state_d = FAULT;
        else if (dn_limit)    begin state_d = IDLE; last_dir_d = DN; end
        else if (obstruct)    state_d = DEAD;
        else if (act_edge)    begin state_d = IDLE; last_dir_d = DN; end
        else if (run_expired) state_d = FAULT;
      end
      MOVE_UP: begin
        if (both_limits)      state_d = FAULT;
        else if (up_limit)    begin state_d = IDLE; last_dir_d = UP; end
        else if (act_edge)    begin state_d = IDLE; last_dir_d = UP; end
        else if (run_expired) state_d = FAULT;
      end
      // Only a downward obstruction reaches DEAD, so the pending direction is always up.
      DEAD: begin
        if (both_limits)    state_d = FAULT;
        else if (dead_done) state_d = MOVE_UP;
      end
      FAULT: begin
        if (clear_fault) state_d = IDLE;
      end
      default: state_d = FAULT;
    endcase
  end

  always_comb begin
    motor_up_d = (state_d == MOVE_UP);
    motor_dn_d = (state_d == MOVE_DN);
    fault_d    = (state_d == FAULT);
  end

  assign motor_up = motor_up_q;
  assign motor_dn = motor_dn_q;
  assign fault    = fault_q;
  assign state_o  = state_q;

endmodule

`default_nettype wire
